// File: rtl/writeback_unit_if.sv
// rtl/writeback_unit_if.sv - ALU/load response streams and register-file write port of writeback_unit
interface writeback_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int AW         = 5
);
  logic                  alu_valid_i;
  logic                  alu_ready_o;
  logic [AW-1:0]         alu_rd_addr_i;
  logic [DATA_WIDTH-1:0] alu_result_i;
  logic                  lsu_valid_i;
  logic                  lsu_ready_o;
  logic [AW-1:0]         lsu_rd_addr_i;
  logic [2:0]            lsu_funct3_i;
  logic [1:0]            lsu_addr_lo_i;
  logic [DATA_WIDTH-1:0] lsu_rdata_i;
  logic                  rf_we_o;
  logic [AW-1:0]         rf_rd_addr_o;
  logic [DATA_WIDTH-1:0] rf_rd_o;
  logic                  err_o;
  logic [31:0]           retired_o;

  modport slave (
      input  alu_valid_i, alu_rd_addr_i, alu_result_i,
      input  lsu_valid_i, lsu_rd_addr_i, lsu_funct3_i, lsu_addr_lo_i, lsu_rdata_i,
      output alu_ready_o, lsu_ready_o,
      output rf_we_o, rf_rd_addr_o, rf_rd_o, err_o, retired_o
  );

  modport master (
      output alu_valid_i, alu_rd_addr_i, alu_result_i,
      output lsu_valid_i, lsu_rd_addr_i, lsu_funct3_i, lsu_addr_lo_i, lsu_rdata_i,
      input  alu_ready_o, lsu_ready_o,
      input  rf_we_o, rf_rd_addr_o, rf_rd_o, err_o, retired_o
  );
endinterface

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - arbitrates ALU/load results into the register file write port
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module writeback_unit #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_REGISTER = 32
) (
    input logic            clk_i,
    input logic            rst_n_i,
    writeback_unit_if.slave wb
);
  localparam int AW = $clog2(NUM_REGISTER);

  logic                  alu_starved_q;
  logic                  alu_starved_d;
  logic                  alu_grant;
  logic                  lsu_grant;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  funct3_illegal;
  logic [AW-1:0]         win_addr;
  logic [DATA_WIDTH-1:0] win_data;

  logic                  rf_we_q;
  logic [AW-1:0]         rf_rd_addr_q;
  logic [DATA_WIDTH-1:0] rf_rd_q;
  logic                  err_q;

  // The load normally wins a conflict; a passed-over ALU wins the next one.
  always_comb begin
    alu_grant = 1'b0;
    lsu_grant = 1'b0;
    if (rst_n_i) begin
      alu_grant = wb.alu_valid_i && (!wb.lsu_valid_i || alu_starved_q);
      lsu_grant = wb.lsu_valid_i && !(wb.alu_valid_i && alu_starved_q);
    end
  end

  assign alu_starved_d  = wb.alu_valid_i && !alu_grant;
  assign wb.alu_ready_o = alu_grant;
  assign wb.lsu_ready_o = lsu_grant;

  always_comb begin
    byte_sel       = wb.lsu_rdata_i[{wb.lsu_addr_lo_i, 3'b000} +: 8];
    half_sel       = wb.lsu_addr_lo_i[1] ? wb.lsu_rdata_i[31:16] : wb.lsu_rdata_i[15:0];
    funct3_illegal = 1'b0;
    case (wb.lsu_funct3_i)
      3'b000:  load_data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
      3'b010:  load_data = wb.lsu_rdata_i;
      3'b100:  load_data = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
      3'b101:  load_data = {{(DATA_WIDTH-16){1'b0}}, half_sel};
      default: begin
        load_data      = wb.lsu_rdata_i;
        funct3_illegal = 1'b1;
      end
    endcase
  end

  always_comb begin
    win_addr = wb.lsu_rd_addr_i;
    win_data = load_data;
    if (alu_grant) begin
      win_addr = wb.alu_rd_addr_i;
      win_data = wb.alu_result_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      alu_starved_q <= 1'b0;
      rf_we_q       <= 1'b0;
      rf_rd_addr_q  <= '0;
      rf_rd_q       <= '0;
      err_q         <= 1'b0;
    end else begin
      alu_starved_q <= alu_starved_d;
      rf_we_q       <= (alu_grant || lsu_grant) && (win_addr != '0);
      err_q         <= lsu_grant && funct3_illegal;
      if (alu_grant || lsu_grant) begin
        rf_rd_addr_q <= win_addr;
        rf_rd_q      <= win_data;
      end
    end
  end

  assign wb.rf_we_o      = rf_we_q;
  assign wb.rf_rd_addr_o = rf_rd_addr_q;
  assign wb.rf_rd_o      = rf_rd_q;
  assign wb.err_o        = err_q;

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retired_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      retired_q <= '0;
    end else if (rf_we_q) begin
      retired_q <= retired_q + 32'd1;
    end
  end

  assign wb.retired_o = retired_q;
`else
  assign wb.retired_o = 32'd0;
`endif
endmodule

// File: tb/tb_writeback_unit.sv
// tb/tb_writeback_unit.sv - randomized self-checking bench for writeback_unit against a behavioural model
module tb_writeback_unit;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  writeback_unit_if #(.DATA_WIDTH(32), .AW(5)) wb ();

  writeback_unit #(.DATA_WIDTH(32), .NUM_REGISTER(32)) dut (
      .clk_i  (clk),
      .rst_n_i(rst_n),
      .wb     (wb)
  );

  int checks = 0;
  int errors = 0;

  // model state
  bit          alu_waited = 0;
  bit          exp_we = 0;
  logic [4:0]  exp_addr = '0;
  logic [31:0] exp_data = '0;
  bit          exp_err = 0;
  logic [31:0] exp_ret = '0;
  bit          last_ga, last_gl;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] f, input logic [1:0] off,
                                           input logic [31:0] w);
    int unsigned b, h;
    b = (w >> (int'(off) * 8)) & 32'hFF;
    h = (off >= 2) ? (w >> 16) : (w & 32'hFFFF);
    case (f)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  task automatic set_alu(input bit v, input logic [4:0] rd, input logic [31:0] res);
    wb.alu_valid_i   = v;
    wb.alu_rd_addr_i = rd;
    wb.alu_result_i  = res;
  endtask

  task automatic set_lsu(input bit v, input logic [4:0] rd, input logic [2:0] f,
                         input logic [1:0] off, input logic [31:0] w);
    wb.lsu_valid_i   = v;
    wb.lsu_rd_addr_i = rd;
    wb.lsu_funct3_i  = f;
    wb.lsu_addr_lo_i = off;
    wb.lsu_rdata_i   = w;
  endtask

  // One clock: check readies mid-cycle, then the registered outputs after the edge.
  task automatic run_cycle();
    bit          ga, gl, rst_now, illegal;
    logic [4:0]  a;
    logic [31:0] d;
    @(negedge clk);
    ga = 0;
    gl = 0;
    rst_now = !rst_n;
    if (!rst_now) begin
      if (wb.alu_valid_i && wb.lsu_valid_i) begin
        if (alu_waited) ga = 1;
        else gl = 1;
      end else if (wb.alu_valid_i) ga = 1;
      else if (wb.lsu_valid_i) gl = 1;
    end
    check("alu_ready", {31'd0, wb.alu_ready_o}, {31'd0, ga});
    check("lsu_ready", {31'd0, wb.lsu_ready_o}, {31'd0, gl});
    a = ga ? wb.alu_rd_addr_i : wb.lsu_rd_addr_i;
    d = ga ? wb.alu_result_i : ref_load(wb.lsu_funct3_i, wb.lsu_addr_lo_i, wb.lsu_rdata_i);
    illegal = (wb.lsu_funct3_i == 3'd3) || (wb.lsu_funct3_i == 3'd6) || (wb.lsu_funct3_i == 3'd7);
    @(posedge clk);
    #1;
    if (rst_now) begin
      alu_waited = 0;
      exp_we = 0;
      exp_addr = '0;
      exp_data = '0;
      exp_err = 0;
      exp_ret = '0;
    end else begin
`ifdef WB_RETIRE_CNT_EN
      exp_ret = exp_ret + (exp_we ? 32'd1 : 32'd0);
`endif
      exp_we = (ga || gl) && (a != 0);
      if (ga || gl) begin
        exp_addr = a;
        exp_data = d;
      end
      exp_err = gl && illegal;
      alu_waited = wb.alu_valid_i && !ga;
    end
    last_ga = ga;
    last_gl = gl;
    check("rf_we", {31'd0, wb.rf_we_o}, {31'd0, exp_we});
    check("rf_addr", {27'd0, wb.rf_rd_addr_o}, {27'd0, exp_addr});
    check("rf_data", wb.rf_rd_o, exp_data);
    check("err", {31'd0, wb.err_o}, {31'd0, exp_err});
    check("retired", wb.retired_o, exp_ret);
  endtask

  typedef struct {
    logic [2:0]  f;
    logic [1:0]  off;
    logic [31:0] exp;
  } ld_vec_t;

  ld_vec_t ld_tab[5] = '{
      '{3'b000, 2'd3, 32'hFFFF_FF82},
      '{3'b100, 2'd0, 32'h0000_0080},
      '{3'b001, 2'd2, 32'hFFFF_8281},
      '{3'b101, 2'd0, 32'h0000_7F80},
      '{3'b011, 2'd1, 32'h8281_7F80}
  };

  initial begin
    logic [31:0] ret_save;
    // reset with both producers requesting: readies must stay low
    rst_n = 1'b0;
    set_alu(1, 5'd3, 32'h1234_5678);
    set_lsu(1, 5'd4, 3'b010, 2'd0, 32'hCAFE_F00D);
    run_cycle();
    run_cycle();
    rst_n = 1'b1;
    set_alu(0, 5'd0, 32'd0);
    set_lsu(0, 5'd0, 3'b010, 2'd0, 32'd0);
    run_cycle();
    run_cycle();

    // single ALU write
    set_alu(1, 5'd5, 32'h0000_00A5);
    run_cycle();
    check("single_we", {31'd0, wb.rf_we_o}, 32'd1);
    check("single_addr", {27'd0, wb.rf_rd_addr_o}, 32'd5);
    check("single_data", wb.rf_rd_o, 32'h0000_00A5);
    set_alu(0, 5'd0, 32'd0);
    run_cycle();
    check("single_we_drop", {31'd0, wb.rf_we_o}, 32'd0);

    // load extraction table
    foreach (ld_tab[i]) begin
      set_lsu(1, 5'd7, ld_tab[i].f, ld_tab[i].off, 32'h8281_7F80);
      run_cycle();
      check("ld_data", wb.rf_rd_o, ld_tab[i].exp);
      check("ld_err", {31'd0, wb.err_o}, (ld_tab[i].f == 3'b011) ? 32'd1 : 32'd0);
      set_lsu(0, 5'd0, 3'b010, 2'd0, 32'd0);
      run_cycle();
      check("err_pulse_end", {31'd0, wb.err_o}, 32'd0);
    end

    // conflict and fairness: load, ALU, load
    set_alu(1, 5'd1, 32'h1111_1111);
    set_lsu(1, 5'd2, 3'b010, 2'd0, 32'h2222_2222);
    run_cycle();
    check("conflict_1", {27'd0, wb.rf_rd_addr_o}, 32'd2);
    run_cycle();
    check("conflict_2", {27'd0, wb.rf_rd_addr_o}, 32'd1);
    run_cycle();
    check("conflict_3", {27'd0, wb.rf_rd_addr_o}, 32'd2);
    set_alu(0, 5'd0, 32'd0);
    set_lsu(0, 5'd0, 3'b010, 2'd0, 32'd0);
    run_cycle();
    run_cycle();

    // x0 suppression
    ret_save = exp_ret;
    set_alu(1, 5'd0, 32'hFFFF_FFFF);
    run_cycle();
    check("x0_ready_taken", {31'd0, last_ga}, 32'd1);
    check("x0_we", {31'd0, wb.rf_we_o}, 32'd0);
    set_alu(0, 5'd0, 32'd0);
    run_cycle();
    check("x0_retired", wb.retired_o, ret_save);

    // reset mid-flight
    rst_n = 1'b0;
    run_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_alu(1, 5'(i + 3), 32'(i * 7 + 1));
      run_cycle();
    end
    set_alu(0, 5'd0, 32'd0);
    run_cycle();
`ifdef WB_RETIRE_CNT_EN
    check("retired_three", wb.retired_o, 32'd3);
`else
    check("retired_tied", wb.retired_o, 32'd0);
`endif
    set_alu(1, 5'd6, 32'h6666_6666);
    run_cycle();
    check("pre_reset_we", {31'd0, wb.rf_we_o}, 32'd1);
    rst_n = 1'b0;
    set_alu(0, 5'd0, 32'd0);
    run_cycle();
    check("reset_drop_we", {31'd0, wb.rf_we_o}, 32'd0);
    check("reset_retired", wb.retired_o, 32'd0);
    rst_n = 1'b1;

    // randomized traffic with producers holding payload until accepted
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      if (!(wb.alu_valid_i && !last_ga)) begin
        set_alu($urandom_range(0, 99) < 60, 5'($urandom_range(0, 31) < 4 ? 0 : $urandom_range(1, 31)),
                $urandom);
      end
      if (!(wb.lsu_valid_i && !last_gl)) begin
        set_lsu($urandom_range(0, 99) < 60, 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)),
                2'($urandom_range(0, 3)), $urandom);
      end
      run_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/writeback_unit.md
# writeback_unit

Write-side counterpart of `register_file` in the RV32I core. It arbitrates between the ALU result stream and the load-response stream from the data-memory interface. It extracts and sign/zero-extends load data, suppresses writes to x0, and drives the register file write port (`we_i`, `rd_addr_i`, `rd_i`) from registered outputs. It sits between execute/memory and `register_file`.

## Interface
Parameters (from `pkg_config`):
- `DATA_WIDTH`, 32, register/data width.
- `NUM_REGISTER`, 32, register count; address width `AW = $clog2(NUM_REGISTER)`.

Ports:
- `clk_i`  in  1  core clock.
- `rst_n_i`  in  1  reset, synchronous, active-low.
- `alu_valid_i`  in  1  ALU result valid.
- `alu_ready_o`  out  1  ALU result accepted this cycle.
- `alu_rd_addr_i`  in  AW  ALU destination register.
- `alu_result_i`  in  DATA_WIDTH  ALU result.
- `lsu_valid_i`  in  1  load response valid.
- `lsu_ready_o`  out  1  load response accepted this cycle.
- `lsu_rd_addr_i`  in  AW  load destination register.
- `lsu_funct3_i`  in  3  load type (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
- `lsu_addr_lo_i`  in  2  byte offset of the load address.
- `lsu_rdata_i`  in  DATA_WIDTH  raw aligned memory word.
- `rf_we_o`  out  1  register file write enable.
- `rf_rd_addr_o`  out  AW  register file write address.
- `rf_rd_o`  out  DATA_WIDTH  register file write data.
- `err_o`  out  1  one-cycle pulse on an illegal `lsu_funct3_i`.
- `retired_o`  out  32  count of committed writes (see Configuration).

## Operation
- Handshake: a transfer occurs when valid && ready in the same cycle. Producers hold payload stable while valid && !ready. Ready outputs are combinational from the valids and `alu_starved_q`.
- Arbitration, one grant per cycle:
  - Only one source valid: that source is granted.
  - Both valid: the load wins, unless `alu_starved_q` = 1, in which case the ALU wins.
  - `alu_starved_q` is set when the ALU is valid and not granted. It clears when the ALU is granted or `alu_valid_i` = 0.
  - An ALU request therefore waits at most 1 cycle.
- Load extraction (byte lane = `lsu_addr_lo_i`):
  - LB/LBU: byte `rdata[8*off+7 : 8*off]`, sign-/zero-extended.
  - LH/LHU: halfword selected by `off[1]` (`off[0]` ignored), sign-/zero-extended.
  - LW: full word; offset ignored.
  - Illegal funct3 (011, 110, 111): the transfer is still accepted, written data = LW extraction, and `err_o` pulses the following cycle.
- x0 rule: a granted transfer with rd_addr = 0 is consumed (ready high), but `rf_we_o` stays 0 and `retired_o` does not increment.
- Output registers: on a grant, `rf_rd_addr_o`/`rf_rd_o` load the winner's address/data and `rf_we_o` = (addr != 0). With no grant, `rf_we_o` = 0 and addr/data hold their previous values.

## Timing
- Latency: a grant in cycle N gives `rf_we_o` = 1 in cycle N+1, for exactly one cycle per grant. The register file commits at the N+1→N+2 edge.
- Throughput: one write per cycle. Back-to-back grants produce a continuous `rf_we_o` = 1.
- Reset (`rst_n_i` = 0 at a rising edge):
  - `rf_we_o`, `rf_rd_addr_o`, `rf_rd_o`, `err_o`, `alu_starved_q`, `retired_o` all become 0.
  - Both ready outputs are forced 0 while reset is low.
  - A grant registered just before reset is dropped: `rf_we_o` = 0 in the cycle after the reset edge.
- Simultaneous valid with the same rd_addr: only the winner is written this cycle. The loser is written in a later cycle (program-order hazards are the pipeline's responsibility).

## Configuration
- `WB_RETIRE_CNT_EN` defined:
  - `retired_o` is a 32-bit counter incrementing by 1 at every edge where `rf_we_o` = 1.
  - It wraps from 0xFFFF_FFFF to 0 and is cleared by reset.
- Undefined: `retired_o` is tied to 0 and the counter logic is removed.

## Test plan
- Reset then idle: hold `rst_n_i` = 0 for 2 edges → all outputs 0 and both readies 0. After release, no valids → `rf_we_o` stays 0.
- Single ALU write: alu_valid, rd = 5, result = 0x0000_00A5 → `alu_ready_o` = 1 that cycle. Next cycle `rf_we_o` = 1, addr = 5, data = 0x0000_00A5. Cycle after: `rf_we_o` = 0.
- Load extraction: `rdata` = 0x8281_7F80:
  - LB off=3 → 0xFFFF_FF82.
  - LBU off=0 → 0x0000_0080.
  - LH off=2 → 0xFFFF_8281.
  - LHU off=0 → 0x0000_7F80.
  - funct3 = 011 → data 0x8281_7F80 and `err_o` pulse.
- Conflict and fairness: both valid for 3 cycles (ALU rd = 1, load rd = 2) → grants in order load, ALU, load, with `rf_rd_addr_o` = 2, 1, 2 on consecutive cycles.
- x0 suppression: ALU rd = 0, result = 0xFFFF_FFFF → `alu_ready_o` = 1, `rf_we_o` stays 0, `retired_o` unchanged.
- Reset mid-flight with `WB_RETIRE_CNT_EN`:
  - Three writes → `retired_o` = 3.
  - A grant in cycle N with reset low at the N+1 edge → `rf_we_o` = 0 after that edge and `retired_o` = 0.
